arp_rx_multi: RTL and testbench
===============================

ARP_RX_MULTI -- requirements
Module: arp_rx_multi

Interface
REQ-001 SHALL have parameter NUM_IP, default 2, giving the number of local IPv4 addresses matched (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the event FIFO depth (power of 2, 2..16).
REQ-003 SHALL have parameter GARP_EN, default 1; when 1, gratuitous ARP (SPA==TPA) is reported.
REQ-004 SHALL have one clock and a synchronous active-high reset: mac_gmii_rx_clk in 1 (rising edge), mac_gmii_rx_rst in 1 (synchronous, active-high).
REQ-005 SHALL have these inputs: mac_gmii_rxd in 8 (GMII byte); mac_gmii_rx_dv in 1 (byte valid); mac_gmii_rx_er in 1 (byte error); eth_type_arp_valid in 1 (current byte is ARP byte 0); crc_rx_valid in 2 (01 = frame CRC good, 10 = bad, 00/11 = none); local_ip in NUM_IP*32 (entry i at bits [32i+31:32i]); local_mac in 48.
REQ-006 SHALL have these event outputs: evt_valid out 1; evt_ready in 1; evt_oper out 2 (01 = request, 10 = reply, 11 = gratuitous); evt_sha out 48; evt_spa out 32; evt_idx out 3 (matched local_ip index).
REQ-007 SHALL have output drop_cnt out 16, counting events lost to a full FIFO.

Function
REQ-008 Data valid SHALL mean mac_gmii_rx_dv=1 and mac_gmii_rx_er=0.
REQ-009 FSM states SHALL be IDLE, HDR, OPER, SHA, SPA, THA, TPA, WAIT_CRC, COMMIT, with a 5-bit byte counter.
REQ-010 IDLE SHALL move to HDR on data valid with eth_type_arp_valid=1; that byte is ARP byte 0.
REQ-011 HDR SHALL check bytes 0-5 against 00 01 08 00 06 04 one byte per cycle; any mismatch SHALL go to IDLE.
REQ-012 OPER SHALL accept 00 01 (request) or 00 02 (reply); any other value SHALL go to IDLE.
REQ-013 SHA (6 bytes), SPA (4), THA (6) and TPA (4) SHALL be captured MSB-first; the last TPA byte SHALL go to WAIT_CRC.
REQ-014 In HDR through TPA, loss of data valid SHALL discard the frame and go to IDLE.
REQ-015 In WAIT_CRC, dv is ignored; mac_gmii_rx_dv=1 with mac_gmii_rx_er=1 SHALL discard the frame (IDLE).
REQ-016 In WAIT_CRC, crc_rx_valid=01 SHALL go to COMMIT; 10 SHALL go to IDLE; 00/11 SHALL hold.
REQ-017 COMMIT SHALL last one cycle, SHALL evaluate a match, SHALL push at most one event, then go to IDLE.
REQ-018 Match priority 1: if GARP_EN=1 and SPA==TPA, SHALL push oper=11, idx=0.
REQ-019 Match priority 2: request with TPA==local_ip[i] SHALL push oper=01, idx=lowest matching i.
REQ-020 Match priority 3: reply with TPA==local_ip[i] and THA==local_mac SHALL push oper=10, idx=lowest matching i.
REQ-021 If no match rule applies, COMMIT SHALL push nothing.
REQ-022 The event FIFO SHALL be first-word-fall-through with registered outputs.
REQ-023 An event is popped when evt_valid and evt_ready are both 1; evt_* SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-024 Latency: crc_rx_valid=01 at cycle T SHALL give evt_valid=1 at T+2 when the FIFO is empty.
REQ-025 A push when full SHALL be dropped, even if a pop occurs in the same cycle, and drop_cnt SHALL increment.
REQ-026 drop_cnt SHALL saturate at FFFF.
REQ-027 A pop from an empty FIFO SHALL have no effect.
REQ-028 A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-029 Captured fields of a discarded frame SHALL never reach the FIFO.
REQ-030 A new frame start SHALL not corrupt a pending COMMIT.

Reset
REQ-031 mac_gmii_rx_rst=1 at a clock edge SHALL set FSM=IDLE, counter=0, FIFO empty, evt_valid=0, evt_oper=0, evt_sha=0, evt_spa=0, evt_idx=0, drop_cnt=0.
REQ-032 Reset asserted mid-frame or mid-COMMIT SHALL discard the frame with no event pushed.
REQ-033 The event FIFO storage array SHALL need no reset.

Verification
REQ-034 Request for TPA=C0A80102, local_ip[1]=C0A80102, local_ip[0]=C0A80101, SHA=001122334455, SPA=C0A80105, crc 01 -> evt oper=01, idx=1, sha=001122334455, spa=C0A80105 at T+2.
REQ-035 Reply with TPA=local_ip[0] and THA!=local_mac, crc 01 -> no event; same frame with THA=local_mac -> oper=10, idx=0.
REQ-036 GARP_EN=1, SPA=TPA=C0A80109, crc 01 -> oper=11, idx=0; same frame with crc 10 -> no event.
REQ-037 Bad HTYPE 0006, OPER 0003, or dv dropped at SHA byte 3 -> no event, FSM back in IDLE, next valid frame accepted.
REQ-038 FIFO_DEPTH=4, evt_ready=0, 6 matching frames -> 4 events held in order, drop_cnt=2; assert evt_ready -> 4 pops in arrival order.
REQ-039 Reset pulse during TPA byte 2 -> evt_valid=0, drop_cnt=0; following frame processed normally.

Source files
------------

// File: rtl/arp_rx_multi_if.sv
// Event stream carrying one accepted ARP request/reply/gratuitous notice per transfer.
// A transfer happens on a clock edge where evt_valid and evt_ready are both high;
// while evt_valid is high and evt_ready low, the master holds every evt_* field steady.
interface arp_rx_multi_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_oper;
  logic [47:0] evt_sha;
  logic [31:0] evt_spa;
  logic [2:0]  evt_idx;

  modport master (output evt_valid, evt_oper, evt_sha, evt_spa, evt_idx, input evt_ready);
  modport slave  (input evt_valid, evt_oper, evt_sha, evt_spa, evt_idx, output evt_ready);
endinterface

// File: rtl/arp_rx_multi.sv
// GMII-side ARP receiver: parses ARP payload bytes, waits for the frame CRC verdict,
// matches against several local IPs and queues one event per accepted frame.
module arp_rx_multi #(
  parameter int NUM_IP     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int GARP_EN    = 1
) (
  input  logic                 mac_gmii_rx_clk,
  input  logic                 mac_gmii_rx_rst,
  input  logic [7:0]           mac_gmii_rxd,
  input  logic                 mac_gmii_rx_dv,
  input  logic                 mac_gmii_rx_er,
  input  logic                 eth_type_arp_valid,
  input  logic [1:0]           crc_rx_valid,
  input  logic [NUM_IP*32-1:0] local_ip,
  input  logic [47:0]          local_mac,
  arp_rx_multi_if.master       evt,
  output logic [15:0]          drop_cnt,
  output logic [3:0]           dbg_state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, HDR, OPER, SHA, SPA, THA, TPA, WAIT_CRC, COMMIT
  } state_t;

  typedef struct packed {
    logic [1:0]  oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [2:0]  idx;
  } evt_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_req;
  logic [47:0] sha, tha;
  logic [31:0] spa, tpa;
  logic        dv_ok, in_frame;

  assign dv_ok     = mac_gmii_rx_dv & ~mac_gmii_rx_er;
  assign in_frame  = (state == HDR) || (state == OPER) || (state == SHA) ||
                     (state == SPA) || (state == THA) || (state == TPA);
  assign dbg_state = state;

  function automatic logic [7:0] hdr_byte(input logic [4:0] i);
    case (i)
      5'd1:    return 8'h01;
      5'd2:    return 8'h08;
      5'd3:    return 8'h00;
      5'd4:    return 8'h06;
      5'd5:    return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge mac_gmii_rx_clk) begin
    if (mac_gmii_rx_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_req <= 1'b0;
      sha    <= '0;
      tha    <= '0;
      spa    <= '0;
      tpa    <= '0;
    end else if (in_frame && !dv_ok) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        // ARP byte 0 arrives in IDLE, so it is checked here and HDR resumes at byte 1.
        IDLE: if (dv_ok && eth_type_arp_valid && mac_gmii_rxd == 8'h00) begin
          state <= HDR;
          cnt   <= 5'd1;
        end
        HDR: begin
          if (mac_gmii_rxd != hdr_byte(cnt)) state <= IDLE;
          else if (cnt == 5'd5) begin state <= OPER; cnt <= '0; end
          else cnt <= cnt + 5'd1;
        end
        OPER: begin
          if (cnt == 5'd0) begin
            if (mac_gmii_rxd != 8'h00) state <= IDLE;
            else cnt <= 5'd1;
          end else if (mac_gmii_rxd == 8'h01 || mac_gmii_rxd == 8'h02) begin
            is_req <= (mac_gmii_rxd == 8'h01);
            state  <= SHA;
            cnt    <= '0;
          end else state <= IDLE;
        end
        SHA: begin
          sha <= {sha[39:0], mac_gmii_rxd};
          if (cnt == 5'd5) begin state <= SPA; cnt <= '0; end
          else cnt <= cnt + 5'd1;
        end
        SPA: begin
          spa <= {spa[23:0], mac_gmii_rxd};
          if (cnt == 5'd3) begin state <= THA; cnt <= '0; end
          else cnt <= cnt + 5'd1;
        end
        THA: begin
          tha <= {tha[39:0], mac_gmii_rxd};
          if (cnt == 5'd5) begin state <= TPA; cnt <= '0; end
          else cnt <= cnt + 5'd1;
        end
        TPA: begin
          tpa <= {tpa[23:0], mac_gmii_rxd};
          if (cnt == 5'd3) begin state <= WAIT_CRC; cnt <= '0; end
          else cnt <= cnt + 5'd1;
        end
        WAIT_CRC: begin
          if (mac_gmii_rx_dv && mac_gmii_rx_er) state <= IDLE;
          else if (crc_rx_valid == 2'b01)      state <= COMMIT;
          else if (crc_rx_valid == 2'b10)      state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic       hit;
  logic [2:0] hit_idx;
  logic       push;
  evt_t       push_evt;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_IP - 1; i >= 0; i--) begin
      if (tpa == local_ip[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    push     = 1'b0;
    push_evt = '{oper: 2'b00, sha: sha, spa: spa, idx: 3'd0};
    if (state == COMMIT) begin
      if (GARP_EN != 0 && spa == tpa) begin
        push          = 1'b1;
        push_evt.oper = 2'b11;
      end else if (hit && is_req) begin
        push          = 1'b1;
        push_evt.oper = 2'b01;
        push_evt.idx  = hit_idx;
      end else if (hit && !is_req && tha == local_mac) begin
        push          = 1'b1;
        push_evt.oper = 2'b10;
        push_evt.idx  = hit_idx;
      end
    end
  end

  // The output register is the FIFO head; mem holds the entries queued behind it.
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt, occ;
  logic          pop, full, push_ok, load_out, rd_mem, wr_mem;

  assign pop      = evt.evt_valid & evt.evt_ready;
  assign occ      = mem_cnt + CW'(evt.evt_valid);
  assign full     = (occ == CW'(FIFO_DEPTH));
  assign push_ok  = push & ~full;
  assign load_out = ~evt.evt_valid | pop;
  assign rd_mem   = load_out & (mem_cnt != '0);
  assign wr_mem   = push_ok & ~(load_out & (mem_cnt == '0));

  always_ff @(posedge mac_gmii_rx_clk) begin
    if (wr_mem) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge mac_gmii_rx_clk) begin
    if (mac_gmii_rx_rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_oper  <= '0;
      evt.evt_sha   <= '0;
      evt.evt_spa   <= '0;
      evt.evt_idx   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      if (load_out) begin
        if (rd_mem) begin
          {evt.evt_oper, evt.evt_sha, evt.evt_spa, evt.evt_idx} <= mem[rd_ptr];
          evt.evt_valid <= 1'b1;
        end else if (push_ok) begin
          {evt.evt_oper, evt.evt_sha, evt.evt_spa, evt.evt_idx} <= push_evt;
          evt.evt_valid <= 1'b1;
        end else begin
          evt.evt_valid <= 1'b0;
        end
      end
      if (rd_mem) rd_ptr <= rd_ptr + AW'(1);
      if (wr_mem) wr_ptr <= wr_ptr + AW'(1);
      mem_cnt <= mem_cnt + CW'(wr_mem) - CW'(rd_mem);
      if (push && full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_arp_rx_multi.sv
// Bench for arp_rx_multi: frame-level reference model feeding an event queue,
// checked every cycle, plus directed frames with hand-computed expectations.
module tb_arp_rx_multi;
  localparam int NUM_IP     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = 85;
  localparam logic [31:0] IP0    = 32'hC0A80101;
  localparam logic [31:0] IP1    = 32'hC0A80102;
  localparam logic [47:0] MY_MAC = 48'h02AABBCCDDEE;

  typedef struct packed {
    logic [1:0]  oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [2:0]  idx;
  } evt_t;

  typedef struct {
    logic [15:0] htype, ptype, oper;
    logic [7:0]  hlen, plen;
    logic [47:0] sha, tha;
    logic [31:0] spa, tpa;
    int          drop_at, rst_at, hold;
    bit          er_wait;
    logic [1:0]  crc;
  } frame_t;

  typedef struct {
    int   due;
    evt_t e;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mac_gmii_rxd = '0;
  logic        mac_gmii_rx_dv = 1'b0, mac_gmii_rx_er = 1'b0, eth_type_arp_valid = 1'b0;
  logic [1:0]  crc_rx_valid = '0;
  logic [63:0] local_ip;
  logic [47:0] local_mac;
  logic [15:0] drop_cnt;
  logic [3:0]  dbg_state;
  logic [31:0] lip [NUM_IP] = '{IP0, IP1};

  logic [EW-1:0] exp_q[$];
  pend_t         pend_q[$];
  int            cyc = 0, drop_exp = 0, n_cmp = 0, n_fail = 0, rdy_pct = 50;
  bit            rand_rdy = 1'b0;
  evt_t          head;

  assign local_ip  = {IP1, IP0};
  assign local_mac = MY_MAC;

  arp_rx_multi_if evt_if();

  arp_rx_multi #(.NUM_IP(NUM_IP), .FIFO_DEPTH(FIFO_DEPTH), .GARP_EN(1)) dut (
    .mac_gmii_rx_clk   (clk),
    .mac_gmii_rx_rst   (rst),
    .mac_gmii_rxd      (mac_gmii_rxd),
    .mac_gmii_rx_dv    (mac_gmii_rx_dv),
    .mac_gmii_rx_er    (mac_gmii_rx_er),
    .eth_type_arp_valid(eth_type_arp_valid),
    .crc_rx_valid      (crc_rx_valid),
    .local_ip          (local_ip),
    .local_mac         (local_mac),
    .evt               (evt_if),
    .drop_cnt          (drop_cnt),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level acceptance and match rules, then a bounded queue.
  function automatic bit model_event(input frame_t f, output evt_t e);
    int m = -1;
    e = '0;
    if (f.htype != 16'h0001 || f.ptype != 16'h0800 || f.hlen != 8'h06 || f.plen != 8'h04) return 1'b0;
    if (f.oper != 16'h0001 && f.oper != 16'h0002) return 1'b0;
    if (f.drop_at >= 0 || f.rst_at >= 0 || f.er_wait || f.crc != 2'b01) return 1'b0;
    e.sha = f.sha;
    e.spa = f.spa;
    if (f.spa == f.tpa) begin
      e.oper = 2'b11;
      return 1'b1;
    end
    for (int i = 0; i < NUM_IP; i++) if (m < 0 && f.tpa == lip[i]) m = i;
    if (m < 0) return 1'b0;
    e.idx = 3'(m);
    if (f.oper == 16'h0001) begin e.oper = 2'b01; return 1'b1; end
    if (f.tha == MY_MAC)    begin e.oper = 2'b10; return 1'b1; end
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      drop_exp = 0;
    end else begin
      automatic bit do_pop = (exp_q.size() > 0) && evt_if.evt_ready;
      while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        if (exp_q.size() >= FIFO_DEPTH) begin
          if (drop_exp < 65535) drop_exp++;
        end else exp_q.push_back(EW'(pend_q[0].e));
        void'(pend_q.pop_front());
      end
      if (do_pop) void'(exp_q.pop_front());
    end
  end

  // Scoreboard compare, every cycle
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("evt_valid", 64'(evt_if.evt_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        head = evt_t'(exp_q[0]);
        chk("evt_oper", 64'(evt_if.evt_oper), 64'(head.oper));
        chk("evt_sha",  64'(evt_if.evt_sha),  64'(head.sha));
        chk("evt_spa",  64'(evt_if.evt_spa),  64'(head.spa));
        chk("evt_idx",  64'(evt_if.evt_idx),  64'(head.idx));
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) evt_if.evt_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic idle(input int n);
    mac_gmii_rx_dv = 1'b0;
    mac_gmii_rx_er = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic frame_t mk(input logic [15:0] oper, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [47:0] tha,
                                input logic [31:0] tpa);
    frame_t f;
    f.htype = 16'h0001; f.ptype = 16'h0800; f.hlen = 8'h06; f.plen = 8'h04;
    f.oper = oper; f.sha = sha; f.spa = spa; f.tha = tha; f.tpa = tpa;
    f.drop_at = -1; f.rst_at = -1; f.hold = 3; f.er_wait = 1'b0; f.crc = 2'b01;
    return f;
  endfunction

  task automatic send_frame(input frame_t f);
    logic [223:0] v;
    evt_t e;
    bit   hit;
    v = {f.htype, f.ptype, f.hlen, f.plen, f.oper, f.sha, f.spa, f.tha, f.tpa};
    for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
      mac_gmii_rx_dv = 1'b1; mac_gmii_rx_er = 1'b0; eth_type_arp_valid = 1'b0;
      mac_gmii_rxd = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 28; i++) begin
      mac_gmii_rxd = v[223-8*i -: 8];
      mac_gmii_rx_dv = 1'b1; mac_gmii_rx_er = 1'b0;
      eth_type_arp_valid = (i == 0);
      rst = (i == f.rst_at);
      if (i == f.drop_at) begin
        if ($urandom_range(0, 1) != 0) mac_gmii_rx_dv = 1'b0;
        else mac_gmii_rx_er = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    eth_type_arp_valid = 1'b0;
    for (int k = 0; k < f.hold; k++) begin
      mac_gmii_rx_dv = 1'($urandom_range(0, 1)); mac_gmii_rx_er = 1'b0;
      mac_gmii_rxd = 8'($urandom);
      crc_rx_valid = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      if (f.er_wait && k == 0) begin mac_gmii_rx_dv = 1'b1; mac_gmii_rx_er = 1'b1; end
      tick();
    end
    mac_gmii_rx_dv = 1'b0; mac_gmii_rx_er = 1'b0;
    crc_rx_valid = f.crc;
    hit = model_event(f, e);
    if (hit) pend_q.push_back('{due: cyc + 2, e: e});
    tick();
    crc_rx_valid = 2'b00;
  endtask

  // Call right after send_frame with an empty FIFO: event must appear exactly at T+2.
  task automatic expect_t2(input string name, input evt_t e);
    @(negedge clk);
    chk({name, "_t1_valid"}, 64'(evt_if.evt_valid), 64'd0);
    @(negedge clk);
    chk({name, "_t2_valid"}, 64'(evt_if.evt_valid), 64'd1);
    chk({name, "_oper"}, 64'(evt_if.evt_oper), 64'(e.oper));
    chk({name, "_idx"},  64'(evt_if.evt_idx),  64'(e.idx));
    chk({name, "_sha"},  64'(evt_if.evt_sha),  64'(e.sha));
    chk({name, "_spa"},  64'(evt_if.evt_spa),  64'(e.spa));
  endtask

  task automatic pop_one();
    tick();
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    idle(2);
  endtask

  task automatic no_event(input string name);
    idle(6);
    chk(name, 64'(evt_if.evt_valid), 64'd0);
  endtask

  initial begin
    frame_t f;
    evt_t   e;
    int     r;
    evt_if.evt_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("rst_oper",  64'(evt_if.evt_oper),  64'd0);
    chk("rst_sha",   64'(evt_if.evt_sha),   64'd0);
    chk("rst_spa",   64'(evt_if.evt_spa),   64'd0);
    chk("rst_idx",   64'(evt_if.evt_idx),   64'd0);
    chk("rst_drop",  64'(drop_cnt),         64'd0);
    chk("rst_state", 64'(dbg_state),        64'd0);
    tick();
    rst = 1'b0;
    idle(3);

    // Request matching local_ip[1]
    send_frame(mk(16'h0001, 48'h001122334455, 32'hC0A80105, 48'h0, 32'hC0A80102));
    expect_t2("req", '{oper: 2'b01, sha: 48'h001122334455, spa: 32'hC0A80105, idx: 3'd1});
    pop_one();

    // Reply: wrong THA then our MAC
    f = mk(16'h0002, 48'h66778899AABB, 32'hC0A80107, 48'hDEADBEEF0001, IP0);
    send_frame(f);
    no_event("reply_bad_tha");
    f.tha = MY_MAC;
    send_frame(f);
    expect_t2("reply", '{oper: 2'b10, sha: 48'h66778899AABB, spa: 32'hC0A80107, idx: 3'd0});
    pop_one();

    // Gratuitous, then the same frame with a bad CRC
    f = mk(16'h0001, 48'hA0A1A2A3A4A5, 32'hC0A80109, 48'h0, 32'hC0A80109);
    send_frame(f);
    expect_t2("garp", '{oper: 2'b11, sha: 48'hA0A1A2A3A4A5, spa: 32'hC0A80109, idx: 3'd0});
    pop_one();
    f.crc = 2'b10;
    send_frame(f);
    no_event("garp_crc_bad");

    // Malformed / truncated frames, then a good one
    f = mk(16'h0001, 48'h111111111111, 32'hC0A8010A, 48'h0, IP0);
    f.htype = 16'h0006;
    send_frame(f);
    no_event("bad_htype");
    chk("bad_htype_state", 64'(dbg_state), 64'd0);
    f = mk(16'h0003, 48'h111111111111, 32'hC0A8010A, 48'h0, IP0);
    send_frame(f);
    no_event("bad_oper");
    chk("bad_oper_state", 64'(dbg_state), 64'd0);
    f = mk(16'h0001, 48'h111111111111, 32'hC0A8010A, 48'h0, IP0);
    f.drop_at = 11;
    send_frame(f);
    no_event("dv_drop");
    chk("dv_drop_state", 64'(dbg_state), 64'd0);
    f.drop_at = -1;
    send_frame(f);
    expect_t2("after_bad", '{oper: 2'b01, sha: 48'h111111111111, spa: 32'hC0A8010A, idx: 3'd0});
    pop_one();

    // Overflow: six events into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      send_frame(mk(16'h0001, 48'h0000000000A0 + 48'(i), 32'hC0A80120, 48'h0, IP1));
      idle(4);
    end
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    tick();
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ovf_order", 64'(evt_if.evt_sha), 64'h0000000000A0 + 64'(k));
    end
    @(negedge clk);
    chk("ovf_empty", 64'(evt_if.evt_valid), 64'd0);
    tick();
    evt_if.evt_ready = 1'b0;

    // Reset mid-TPA with one event already queued and drops recorded
    send_frame(mk(16'h0001, 48'hB0B0B0B0B0B0, 32'hC0A80130, 48'h0, IP0));
    idle(4);
    f = mk(16'h0001, 48'hC0C0C0C0C0C0, 32'hC0A80131, 48'h0, IP1);
    f.rst_at = 26;
    send_frame(f);
    idle(2);
    chk("mid_rst_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("mid_rst_drop",  64'(drop_cnt),         64'd0);
    f.rst_at = -1;
    send_frame(f);
    expect_t2("post_rst", '{oper: 2'b01, sha: 48'hC0C0C0C0C0C0, spa: 32'hC0A80131, idx: 3'd1});
    pop_one();

    // Randomized frames against the model
    rand_rdy = 1'b1;
    for (int n = 0; n < 70; n++) begin
      rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : 80;
      f = mk(16'h0001, {16'($urandom), 32'($urandom)}, 32'($urandom),
             {16'($urandom), 32'($urandom)}, 32'($urandom));
      r = $urandom_range(0, 99);
      f.oper = (r < 45) ? 16'h0001 : (r < 90) ? 16'h0002 : 16'($urandom_range(3, 5));
      r = $urandom_range(0, 3);
      f.tpa = (r == 0) ? IP0 : (r == 1) ? IP1 : (r == 2) ? f.spa : f.tpa;
      if ($urandom_range(0, 1) != 0) f.tha = MY_MAC;
      if ($urandom_range(0, 19) == 0) f.htype = 16'h0006;
      if ($urandom_range(0, 9) == 0) f.drop_at = $urandom_range(1, 27);
      f.hold = $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) begin f.er_wait = 1'b1; f.hold = f.hold + 1; end
      f.crc = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
      send_frame(f);
      idle($urandom_range(1, 4));
    end
    rand_rdy = 1'b0;
    evt_if.evt_ready = 1'b1;
    idle(12);
    chk("drain_empty", 64'(evt_if.evt_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
